fxp_mul_arbiter: RTL



---
 rtl/fxp_pkg.sv | 50 +++++
 rtl/fxp_mul_arbiter_if.sv | 26 ++
 rtl/fxp_mul_pipe.sv | 66 ++++++
 rtl/fxp_mul_arbiter.sv | 69 ++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Q16.16 fixed-point helpers shared by the multiplier pipeline and its bench model.
// The full-width product and the shift/saturate step are split so the pipeline can register between them.
package fxp_pkg;

    localparam int FXP_FRAC = 16;
    localparam logic signed [31:0] FXP_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] FXP_MIN = 32'sh8000_0000;

    typedef struct packed {
        logic        sat;
        logic [31:0] data;
    } fxp_res_t;

    function automatic logic signed [63:0] fxp_mul_full(input logic signed [31:0] a,
                                                        input logic signed [31:0] b);
        logic signed [63:0] aw;
        logic signed [63:0] bw;
        aw = 64'(a);
        bw = 64'(b);
        return aw * bw;
    endfunction

    // Arithmetic shift floors toward -inf before the clamp.
    function automatic fxp_res_t fxp_sat_q16(input logic signed [63:0] p);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        fxp_res_t           res;
        r  = p >>> FXP_FRAC;
        hi = 64'(FXP_MAX);
        lo = 64'(FXP_MIN);
        if (r > hi) begin
            res.sat  = 1'b1;
            res.data = FXP_MAX;
        end else if (r < lo) begin
            res.sat  = 1'b1;
            res.data = FXP_MIN;
        end else begin
            res.sat  = 1'b0;
            res.data = r[31:0];
        end
        return res;
    endfunction

    function automatic fxp_res_t fxp_mul_sat_q16(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
        return fxp_sat_q16(fxp_mul_full(a, b));
    endfunction

endpackage

// File: rtl/fxp_mul_arbiter_if.sv
// Request/response bundle between the requester engines and the shared multiplier.
interface fxp_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0][31:0] req_a;
    logic [NUM_REQ-1:0][31:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [31:0]              rsp_data;
    logic                     rsp_sat;
    logic                     busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_sat, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_sat, busy
    );
endinterface

// File: rtl/fxp_mul_pipe.sv
// MUL_LAT-deep Q16.16 multiply pipeline carrying a valid/id sideband; the whole pipe freezes when en=0.
module fxp_mul_pipe
    import fxp_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    input  logic [ID_W-1:0]    in_id,
    input  logic signed [31:0] in_a,
    input  logic signed [31:0] in_b,
    output logic               out_valid,
    output logic [ID_W-1:0]    out_id,
    output logic [31:0]        out_data,
    output logic               out_sat,
    output logic               busy
);
    logic [MUL_LAT-1:0] vld;
    logic [ID_W-1:0]    id_q [MUL_LAT];
    logic signed [31:0] a_q;
    logic signed [31:0] b_q;
    fxp_res_t           res;

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (en) begin
            vld[0] <= in_valid;
            for (int i = 1; i < MUL_LAT; i++) vld[i] <= vld[i-1];
        end
    end

    // NOTE: payload registers are not reset; the valid bits alone decide whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (en) begin
            id_q[0] <= in_id;
            a_q     <= in_a;
            b_q     <= in_b;
            for (int i = 1; i < MUL_LAT; i++) id_q[i] <= id_q[i-1];
        end
    end

    if (MUL_LAT == 1) begin : g_lat1
        assign res = fxp_mul_sat_q16(a_q, b_q);
    end else begin : g_latn
        // Product is registered after stage 0; later stages only delay it, saturation is done on the way out.
        logic signed [63:0] prod_q [1:MUL_LAT-1];
        always_ff @(posedge clk) begin
            if (en) begin
                prod_q[1] <= fxp_mul_full(a_q, b_q);
                for (int i = 2; i < MUL_LAT; i++) prod_q[i] <= prod_q[i-1];
            end
        end
        assign res = fxp_sat_q16(prod_q[MUL_LAT-1]);
    end

    assign out_valid = vld[MUL_LAT-1];
    assign out_id    = out_valid ? id_q[MUL_LAT-1] : '0;
    assign out_data  = out_valid ? res.data : '0;
    assign out_sat   = out_valid & res.sat;
    assign busy      = |vld;
endmodule

// File: rtl/fxp_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined Q16.16 multiplier among NUM_REQ requesters.
module fxp_mul_arbiter
    import fxp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    fxp_mul_arbiter_if.slave bus
);
    logic            stall;
    logic            can_accept;
    logic            grant_hit;
    logic            accept;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] rr_ptr;
    int              idx;

    assign stall      = bus.rsp_valid & ~bus.rsp_ready;
    assign can_accept = ~stall & rst_n;
    assign accept     = can_accept & grant_hit;

    // NOTE: every combinational output gets a default before the scan, so no path leaves it unassigned (no latch).
    always_comb begin
        grant_hit = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_hit && bus.req_valid[idx]) begin
                grant_hit = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[grant_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    fxp_mul_pipe #(
        .MUL_LAT (MUL_LAT),
        .ID_W    (ID_W)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (~stall),
        .in_valid  (accept),
        .in_id     (grant_id),
        .in_a      (bus.req_a[grant_id]),
        .in_b      (bus.req_b[grant_id]),
        .out_valid (bus.rsp_valid),
        .out_id    (bus.rsp_id),
        .out_data  (bus.rsp_data),
        .out_sat   (bus.rsp_sat),
        .busy      (bus.busy)
    );
endmodule
